// File: rtl/dpr_fifo_ctrl_if.sv
// Control-side bundle between a FIFO user, dpr_fifo_ctrl and the dpr_sync RAM.
// master = request side (user), slave = the FIFO controller.
interface dpr_fifo_ctrl_if #(
  parameter int unsigned ADDR_SIZE = 10
);
  logic                 wr_req;
  logic                 rd_req;
  logic                 wr_en;
  logic                 rd_en;
  logic                 blk_select;
  logic [ADDR_SIZE-1:0] add_wr;
  logic [ADDR_SIZE-1:0] add_rd;
  logic [ADDR_SIZE:0]   count;
  logic                 full;
  logic                 empty;
  logic                 almost_full;
  logic                 almost_empty;
  logic                 rd_valid;
  logic                 overflow;
  logic                 underflow;

  modport master (
    output wr_req, rd_req,
    input  wr_en, rd_en, blk_select, add_wr, add_rd, count,
           full, empty, almost_full, almost_empty, rd_valid, overflow, underflow
  );

  modport slave (
    input  wr_req, rd_req,
    output wr_en, rd_en, blk_select, add_wr, add_rd, count,
           full, empty, almost_full, almost_empty, rd_valid, overflow, underflow
  );
endinterface

// File: rtl/dpr_fifo_ctrl.sv
// Synchronous FIFO controller driving the write/read strobes and addresses of dpr_sync.
// rd_valid lines up with the RAM's registered dout one cycle after a read grant.
module dpr_fifo_ctrl #(
  parameter int unsigned MEM_DEPTH = 1024,
  parameter int unsigned ADDR_SIZE = 10,
  parameter int unsigned AF_LEVEL  = 1020,
  parameter int unsigned AE_LEVEL  = 4
) (
  input logic            clk,
  input logic            rst,
  dpr_fifo_ctrl_if.slave bus
);
  localparam int unsigned CW = ADDR_SIZE + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(MEM_DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);

  logic [ADDR_SIZE-1:0] r_add_wr;
  logic [ADDR_SIZE-1:0] r_add_rd;
  logic [CW-1:0]        r_count;
  logic                 r_rd_valid;
  logic                 r_overflow;
  logic                 r_underflow;

  logic w_full;
  logic w_empty;
  logic w_wr_en;
  logic w_rd_en;

  // Flags come only from the registered count, so they never follow the request inputs.
  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);
  assign w_wr_en = bus.wr_req & ~w_full  & ~rst;
  assign w_rd_en = bus.rd_req & ~w_empty & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_add_wr    <= '0;
      r_add_rd    <= '0;
      r_count     <= '0;
      r_rd_valid  <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      // Pointers wrap naturally because MEM_DEPTH == 2**ADDR_SIZE.
      if (w_wr_en) r_add_wr <= r_add_wr + ADDR_SIZE'(1);
      if (w_rd_en) r_add_rd <= r_add_rd + ADDR_SIZE'(1);
      case ({w_wr_en, w_rd_en})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      r_rd_valid  <= w_rd_en;
      r_overflow  <= bus.wr_req & w_full;
      r_underflow <= bus.rd_req & w_empty;
    end
  end

  assign bus.wr_en        = w_wr_en;
  assign bus.rd_en        = w_rd_en;
  assign bus.blk_select   = w_wr_en | w_rd_en;
  assign bus.add_wr       = r_add_wr;
  assign bus.add_rd       = r_add_rd;
  assign bus.count        = r_count;
  assign bus.full         = w_full;
  assign bus.empty        = w_empty;
  assign bus.almost_full  = (r_count >= AF_CNT);
  assign bus.almost_empty = (r_count <= AE_CNT);
  assign bus.rd_valid     = r_rd_valid;
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;
endmodule
